// File: rtl/maze_render_pkg.sv
// Shared constants, region enum and stage bundles
// for the maze pixel colour pipeline.
package maze_render_pkg;

  localparam logic [11:0] BG   = 12'h00F;
  localparam logic [11:0] WALL = 12'hF00;

  localparam int TOP   = 3;
  localparam int BOT   = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    RG_ID,
    RG_SPR,
    RG_WALL,
    RG_BG
  } region_e;

  typedef struct packed {
    logic        in_id;
    logic        spr_hit;
    logic [11:0] spr_rgb;
    logic        y_ge;
  } s1_t;

  typedef struct packed {
    logic        in_id;
    logic        spr_hit;
    logic [11:0] spr_rgb;
    logic        in_maze;
    logic [10:0] x_in;
    logic [10:0] y_in;
  } s2_t;

  function automatic logic wall_hit(
    input logic [3:0]  w,
    input logic [10:0] xi,
    input logic [10:0] yi,
    input logic [10:0] tw,
    input logic [10:0] th,
    input logic [10:0] m
  );
    return (w[TOP]   && yi <  m)      ||
           (w[BOT]   && yi >= th - m) ||
           (w[LEFT]  && xi <  m)      ||
           (w[RIGHT] && xi >= tw - m);
  endfunction

endpackage

// File: rtl/maze_render_pipe_tile_tracker.sv
// Incremental tile column/row tracker; registered state
// describes the pixel sampled on the previous edge.
module maze_tile_tracker
  import maze_render_pkg::*;
#(
  parameter int TILE_W   = 40,
  parameter int TILE_H   = 40,
  parameter int NUM_COLS = 20,
  parameter int NUM_ROWS = 15,
  parameter int MAZE_Y0  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [10:0] curr_x,
  input  logic [10:0] curr_y,
  output logic [5:0]  col,
  output logic [5:0]  row,
  output logic [10:0] x_in,
  output logic [10:0] y_in
);

  localparam logic [10:0] X_LAST = 11'(TILE_W - 1);
  localparam logic [10:0] Y_LAST = 11'(TILE_H - 1);
  localparam logic [10:0] Y0     = 11'(MAZE_Y0);
  localparam logic [5:0]  C_SAT  = 6'(NUM_COLS);
  localparam logic [5:0]  R_SAT  = 6'(NUM_ROWS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col  <= '0;
      row  <= '0;
      x_in <= '0;
      y_in <= '0;
    end else if (pix_valid) begin
      if (curr_x == '0) begin
        col  <= '0;
        x_in <= '0;
        if (curr_y == Y0) begin
          row  <= '0;
          y_in <= '0;
        end else if (curr_y > Y0) begin
          if (y_in == Y_LAST) begin
            y_in <= '0;
            if (row != R_SAT)
              row <= row + 6'd1;
          end else begin
            y_in <= y_in + 11'd1;
          end
        end
      end else begin
        if (x_in == X_LAST) begin
          x_in <= '0;
          if (col != C_SAT)
            col <= col + 6'd1;
        end else begin
          x_in <= x_in + 11'd1;
        end
      end
    end
  end

endmodule

// File: rtl/maze_render_pipe.sv
// Three-stage maze pixel colour pipeline: ID image,
// sprites, tile walls and background, fixed priority.
module maze_render_pipe
  import maze_render_pkg::*;
#(
  parameter int TILE_W      = 40,
  parameter int TILE_H      = 40,
  parameter int NUM_COLS    = 20,
  parameter int NUM_ROWS    = 15,
  parameter int WALL_MARGIN = 4,
  parameter int MAZE_Y0     = 100,
  parameter int NUM_LEVELS  = 2,
  parameter int NUM_SPR     = 2,
  parameter int SPR_SIZE    = 10,
  parameter int ID_X0       = 1350,
  parameter int ID_Y0       = 120,
  parameter int ID_W        = 128,
  parameter int ID_H        = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  input  logic [10:0]            curr_x,
  input  logic [10:0]            curr_y,
  input  logic [1:0]             level_select,
  input  logic [11*NUM_SPR-1:0]  spr_x,
  input  logic [11*NUM_SPR-1:0]  spr_y,
  input  logic [12*NUM_SPR-1:0]  spr_rgb,
  output logic [1:0]             wall_lvl,
  output logic [4:0]             wall_row,
  output logic [4:0]             wall_col,
  input  logic [3:0]             walls_in,
  output logic [12:0]            id_addr,
  input  logic [11:0]            id_pixel,
  output logic [3:0]             draw_r,
  output logic [3:0]             draw_g,
  output logic [3:0]             draw_b,
  output logic                   draw_valid
);

  localparam int ID_SH = $clog2(ID_W);

  logic [5:0]          col;
  logic [5:0]          row;
  logic [10:0]         x_in;
  logic [10:0]         y_in;
  logic [1:0]          level_q;
  logic [PIPE_LAT-1:0] vld;
  s1_t                 s1;
  s2_t                 s2;

  maze_tile_tracker #(
    .TILE_W   (TILE_W),
    .TILE_H   (TILE_H),
    .NUM_COLS (NUM_COLS),
    .NUM_ROWS (NUM_ROWS),
    .MAZE_Y0  (MAZE_Y0)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .curr_x    (curr_x),
    .curr_y    (curr_y),
    .col       (col),
    .row       (row),
    .x_in      (x_in),
    .y_in      (y_in)
  );

  logic [11:0] x12;
  logic [11:0] y12;
  logic        in_id_c;
  logic [12:0] dx;
  logic [12:0] dy;
  logic [12:0] addr_c;
  logic        frame_start;

  assign x12 = {1'b0, curr_x};
  assign y12 = {1'b0, curr_y};

  assign in_id_c = x12 >= 12'(ID_X0)
                && x12 <  12'(ID_X0 + ID_W)
                && y12 >= 12'(ID_Y0)
                && y12 <  12'(ID_Y0 + ID_H);

  assign dx     = 13'(curr_x) - 13'(ID_X0);
  assign dy     = 13'(curr_y) - 13'(ID_Y0);
  assign addr_c = (dy << ID_SH) + dx;

  assign frame_start = pix_valid
                    && curr_x == '0
                    && curr_y == '0;

  logic        spr_hit_c;
  logic [11:0] spr_col_c;

  // Walk from the highest index down so sprite 0 wins.
  always_comb begin
    spr_hit_c = 1'b0;
    spr_col_c = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (x12 >= {1'b0, spr_x[11*i +: 11]}
       && x12 <  {1'b0, spr_x[11*i +: 11]} + 12'(SPR_SIZE)
       && y12 >= {1'b0, spr_y[11*i +: 11]}
       && y12 <  {1'b0, spr_y[11*i +: 11]} + 12'(SPR_SIZE)) begin
        spr_hit_c = 1'b1;
        spr_col_c = spr_rgb[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld     <= '0;
      s1      <= '0;
      id_addr <= '0;
      level_q <= '0;
    end else begin
      vld        <= {vld[PIPE_LAT-2:0], pix_valid};
      s1.in_id   <= pix_valid & in_id_c;
      s1.spr_hit <= pix_valid & spr_hit_c;
      s1.spr_rgb <= spr_col_c;
      s1.y_ge    <= y12 >= 12'(MAZE_Y0);
      id_addr    <= (pix_valid && in_id_c) ? addr_c : '0;
      if (frame_start)
        level_q <= level_select;
    end
  end

  assign wall_lvl = level_q;
  assign wall_row = row[4:0];
  assign wall_col = col[4:0];

  logic lvl_ok;
  logic in_maze_c;

  assign lvl_ok    = int'(level_q) < NUM_LEVELS;
  assign in_maze_c = s1.y_ge
                  && col < 6'(NUM_COLS)
                  && row < 6'(NUM_ROWS)
                  && lvl_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2 <= '0;
    end else begin
      s2.in_id   <= s1.in_id;
      s2.spr_hit <= s1.spr_hit;
      s2.spr_rgb <= s1.spr_rgb;
      s2.in_maze <= vld[0] & in_maze_c;
      s2.x_in    <= x_in;
      s2.y_in    <= y_in;
    end
  end

  region_e     rg;
  logic [11:0] col_c;
  logic        hit_c;

  assign hit_c = wall_hit(walls_in, s2.x_in, s2.y_in,
                          11'(TILE_W), 11'(TILE_H),
                          11'(WALL_MARGIN));

  always_comb begin
    rg = RG_BG;
    if (s2.in_id)
      rg = RG_ID;
    else if (s2.spr_hit)
      rg = RG_SPR;
    else if (s2.in_maze && hit_c)
      rg = RG_WALL;
    unique case (rg)
      RG_ID:   col_c = id_pixel;
      RG_SPR:  col_c = s2.spr_rgb;
      RG_WALL: col_c = WALL;
      default: col_c = BG;
    endcase
    if (!vld[1])
      col_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draw_r <= '0;
      draw_g <= '0;
      draw_b <= '0;
    end else begin
      draw_r <= col_c[11:8];
      draw_g <= col_c[7:4];
      draw_b <= col_c[3:0];
    end
  end

  assign draw_valid = vld[PIPE_LAT-1];

endmodule

// File: tb/tb_maze_render_pipe.sv
// Randomized raster-scan bench for maze_render_pipe
// with an arithmetic colour model and ROM models.
module tb_maze_render_pipe;

  localparam int TW  = 40;
  localparam int TH  = 40;
  localparam int NC  = 20;
  localparam int NR  = 15;
  localparam int M   = 4;
  localparam int Y0  = 100;
  localparam int NL  = 2;
  localparam int SS  = 10;
  localparam int IX0 = 1350;
  localparam int IY0 = 120;
  localparam int IW  = 128;
  localparam int IH  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [10:0] curr_x;
  logic [10:0] curr_y;
  logic [1:0]  level_select;
  logic [21:0] spr_x;
  logic [21:0] spr_y;
  logic [23:0] spr_rgb;
  logic [1:0]  wall_lvl;
  logic [4:0]  wall_row;
  logic [4:0]  wall_col;
  logic [3:0]  walls_in;
  logic [12:0] id_addr;
  logic [11:0] id_pixel;
  logic [3:0]  draw_r;
  logic [3:0]  draw_g;
  logic [3:0]  draw_b;
  logic        draw_valid;

  always #5 clk = ~clk;

  maze_render_pipe #(
    .NUM_SPR (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .curr_x       (curr_x),
    .curr_y       (curr_y),
    .level_select (level_select),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .spr_rgb      (spr_rgb),
    .wall_lvl     (wall_lvl),
    .wall_row     (wall_row),
    .wall_col     (wall_col),
    .walls_in     (walls_in),
    .id_addr      (id_addr),
    .id_pixel     (id_pixel),
    .draw_r       (draw_r),
    .draw_g       (draw_g),
    .draw_b       (draw_b),
    .draw_valid   (draw_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] wall_fn(input int lvl,
                                         input int r,
                                         input int c);
    logic [31:0] h;
    h = 32'(lvl * 7 + r * 5 + c * 3 + r * c + 8);
    return h[3:0];
  endfunction

  function automatic logic [11:0] id_fn(input logic [12:0] a);
    return a[11:0] ^ {a[12], 11'h2B5};
  endfunction

  // External synchronous ROMs
  always @(posedge clk) begin
    walls_in <= wall_fn(int'(wall_lvl), int'(wall_row),
                        int'(wall_col));
    id_pixel <= id_fn(id_addr);
  end

  int       sx [2];
  int       sy [2];
  bit [11:0] sc [2];
  bit [1:0] mlvl = 2'd0;

  function automatic bit in_id(input int x, input int y);
    return x >= IX0 && x < IX0 + IW && y >= IY0 && y < IY0 + IH;
  endfunction

  function automatic bit [11:0] exp_rgb(input int x, input int y,
                                        input int lvl);
    logic [3:0] w;
    int xi;
    int yi;
    if (in_id(x, y))
      return id_fn(13'((y - IY0) * IW + (x - IX0)));
    for (int i = 0; i < 2; i++)
      if (x >= sx[i] && x < sx[i] + SS && y >= sy[i] && y < sy[i] + SS)
        return sc[i];
    if (y >= Y0 && lvl < NL && x / TW < NC && (y - Y0) / TH < NR) begin
      w  = wall_fn(lvl, (y - Y0) / TH, x / TW);
      xi = x % TW;
      yi = (y - Y0) % TH;
      if ((w[3] && yi < M) || (w[2] && yi >= TH - M) ||
          (w[1] && xi < M) || (w[0] && xi >= TW - M))
        return 12'hF00;
    end
    return 12'h00F;
  endfunction

  bit        hv    [4];
  bit [11:0] hrgb  [4];
  bit [12:0] haddr [4];
  bit [1:0]  hlvl  [4];
  bit        htile [4];
  int        hcol  [4];
  int        hrow  [4];
  int        hy    [4];
  int        cyc = 0;

  task automatic step(input bit v, input int x, input int y,
                      input bit tile_ok);
    int p;
    @(negedge clk);
    p = (cyc + 1) % 4;
    check("draw_valid", 32'(draw_valid), 32'(hv[p]));
    check("draw_rgb", {20'd0, draw_r, draw_g, draw_b}, {20'd0, hrgb[p]});
    p = (cyc + 3) % 4;
    if (hv[p]) begin
      check("id_addr", 32'(id_addr), 32'(haddr[p]));
      check("wall_lvl", 32'(wall_lvl), 32'(hlvl[p]));
      if (htile[p])
        check("wall_col", 32'(wall_col), 32'(hcol[p]));
      if (htile[p] && hy[p] >= Y0)
        check("wall_row", 32'(wall_row), 32'(hrow[p]));
    end
    pix_valid = v;
    curr_x    = 11'(x);
    curr_y    = 11'(y);
    if (v && x == 0 && y == 0)
      mlvl = level_select;
    p = cyc % 4;
    hv[p]    = v;
    hrgb[p]  = v ? exp_rgb(x, y, int'(mlvl)) : 12'd0;
    haddr[p] = in_id(x, y) ? 13'((y - IY0) * IW + (x - IX0)) : 13'd0;
    hlvl[p]  = mlvl;
    htile[p] = tile_ok;
    hcol[p]  = (x / TW < NC) ? x / TW : NC;
    hrow[p]  = (y >= Y0 && (y - Y0) / TH < NR) ? (y - Y0) / TH : NR;
    hy[p]    = y;
    cyc++;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst       = 1'b0;
    pix_valid = 1'b0;
    #1;
    check("rst_draw_valid", 32'(draw_valid), 32'd0);
    check("rst_rgb", {20'd0, draw_r, draw_g, draw_b}, 32'd0);
    check("rst_wall_lvl", 32'(wall_lvl), 32'd0);
    check("rst_wall_col", 32'(wall_col), 32'd0);
    check("rst_id_addr", 32'(id_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hv[i]   = 1'b0;
      hrgb[i] = '0;
    end
    mlvl = 2'd0;
  endtask

  task automatic scan_line(input int y, input int len, input int rst_at);
    bit ok;
    int jx;
    int jy;
    ok = 1'b1;
    for (int x = 0; x < len; x++) begin
      if ($urandom_range(0, 7) == 0) begin
        jx = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 1599));
        jy = ($urandom_range(0, 1) == 1) ? Y0 : 0;
        step(1'b0, jx, jy, 1'b0);
      end
      if (x == rst_at) begin
        reset_pulse();
        ok = 1'b0;
      end
      step(1'b1, x, y, ok);
    end
  endtask

  initial begin
    rst          = 1'b0;
    pix_valid    = 1'b0;
    curr_x       = '0;
    curr_y       = '0;
    level_select = 2'd0;
    spr_x        = '0;
    spr_y        = '0;
    spr_rgb      = '0;
    repeat (2) @(negedge clk);
    check("reset_draw_valid", 32'(draw_valid), 32'd0);
    check("reset_rgb", {20'd0, draw_r, draw_g, draw_b}, 32'd0);
    check("reset_wall_lvl", 32'(wall_lvl), 32'd0);
    check("reset_wall_row", 32'(wall_row), 32'd0);
    check("reset_wall_col", 32'(wall_col), 32'd0);
    check("reset_id_addr", 32'(id_addr), 32'd0);
    rst = 1'b1;

    for (int f = 0; f < 4; f++) begin
      sx[0] = int'($urandom_range(0, 60));
      sy[0] = int'($urandom_range(95, 200));
      sc[0] = (f == 0) ? 12'h0F0 : 12'($urandom());
      if (f == 1) begin
        sx[1] = sx[0] + 5;
        sy[1] = sy[0] + 5;
      end else begin
        sx[1] = int'($urandom_range(0, 60));
        sy[1] = int'($urandom_range(95, 200));
      end
      sc[1]   = (f == 1) ? 12'hFF0 : 12'($urandom());
      spr_x   = {11'(sx[1]), 11'(sx[0])};
      spr_y   = {11'(sy[1]), 11'(sy[0])};
      spr_rgb = {sc[1], sc[0]};
      case (f)
        0:       level_select = 2'd0;
        2:       level_select = 2'd1;
        3:       level_select = 2'd2;
        default: level_select = 2'd3;
      endcase
      scan_line(0, 60, (f == 3) ? 30 : -1);
      for (int y = 90; y < 220; y++) begin
        if (f == 0 && y == 150)
          level_select = 2'd3;
        scan_line(y, (y == 150) ? 880 : int'($urandom_range(40, 120)), -1);
        if (y >= IY0 && y < IY0 + IH) begin
          if (y == IY0)
            step(1'b1, IX0, y, 1'b0);
          if (y == IY0 + IH - 1)
            step(1'b1, IX0 + IW - 1, y, 1'b0);
          repeat (2)
            step(1'b1, int'($urandom_range(IX0, IX0 + IW - 1)), y, 1'b0);
        end
      end
      repeat (5) step(1'b0, 0, 0, 1'b0);
    end
    repeat (4) step(1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
